spi_host_cmd_ctrl: RTL

- Command sequencer between the SPI slave byte shifter and the board resources: SDRAM loader port, key matrix, CPU run/reset and config register.
- Decodes the host protocol frame by frame (frame = spi_cs_n low period) and streams bulk-load bytes into SDRAM through a single-entry request/ack port.
- Supplies the byte that the shifter returns on MISO during the next byte slot.

---
 rtl/spi_host_cmd_ctrl_pkg.sv | 38 +++
 rtl/spi_host_cmd_ctrl_if.sv | 43 ++++
 rtl/spi_host_cmd_ctrl_sdram_wr_port.sv | 64 ++++++
 rtl/spi_host_cmd_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_host_cmd_ctrl_pkg.sv
// Package for the SPI host command sequencer.
// Contents: host command codes, the sequencer state enum, the status byte
// bit positions and a helper that assembles the status byte.
package spi_host_cmd_pkg;

    localparam logic [7:0] CMD_PING   = 8'h00;
    localparam logic [7:0] CMD_RUN    = 8'h02;
    localparam logic [7:0] CMD_KEY    = 8'h03;
    localparam logic [7:0] CMD_LOAD   = 8'h04;
    localparam logic [7:0] CMD_STATUS = 8'h05;
    localparam logic [7:0] CMD_CPURST = 8'h06;
    localparam logic [7:0] CMD_CONFIG = 8'h07;

    // Status byte layout: bit0 = SDRAM busy (init or request pending),
    // bit1 = a load byte was dropped since the last status read.
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_OVF_BIT  = 1;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ARG_Y,
        ST_ARG_X,
        ST_ARG_BANK,
        ST_STREAM,
        ST_ARG_CFG,
        ST_STAT,
        ST_DISCARD
    } state_t;

    function automatic logic [7:0] status_byte(input logic ovf, input logic busy);
        logic [7:0] v;
        v                = 8'h00;
        v[STAT_OVF_BIT]  = ovf;
        v[STAT_BUSY_BIT] = busy;
        return v;
    endfunction

endpackage

// File: rtl/spi_host_cmd_ctrl_if.sv
// Signal bundle between the command sequencer and its surroundings
// (SPI byte shifter, SDRAM loader port, key matrix, CPU control, config).
//   master : the sequencer's view (drives tx_data, sdram_*, key_*, cpu_*, config_reg)
//   slave  : the environment's view (drives frame/rx pulses, init_busy, ack)
//
// SDRAM handshake: sdram_req is a request/ack pair rather than valid/ready.
// sdram_req rises together with stable sdram_address/sdram_wdata and holds
// until the cycle after a one-cycle sdram_ack; address and data do not change
// while sdram_req is high and no ack has been seen. An ack in the same cycle
// as a new byte frees the slot, so the new byte becomes the next request.
interface spi_host_cmd_ctrl_if #(
    parameter int BANK_W   = 8,
    parameter int OFFSET_W = 14
);
    logic                       frame_start;
    logic                       frame_end;
    logic                       rx_valid;
    logic [7:0]                 rx_data;
    logic [7:0]                 tx_data;
    logic                       sdram_init_busy;
    logic                       sdram_req;
    logic                       sdram_ack;
    logic [BANK_W+OFFSET_W-1:0] sdram_address;
    logic [7:0]                 sdram_wdata;
    logic                       key_we;
    logic [3:0]                 key_y;
    logic [7:0]                 key_x;
    logic                       cpu_reset_req;
    logic                       cpu_run;
    logic [7:0]                 config_reg;

    modport master (
        input  frame_start, frame_end, rx_valid, rx_data, sdram_init_busy, sdram_ack,
        output tx_data, sdram_req, sdram_address, sdram_wdata,
               key_we, key_y, key_x, cpu_reset_req, cpu_run, config_reg
    );

    modport slave (
        output frame_start, frame_end, rx_valid, rx_data, sdram_init_busy, sdram_ack,
        input  tx_data, sdram_req, sdram_address, sdram_wdata,
               key_we, key_y, key_x, cpu_reset_req, cpu_run, config_reg
    );
endinterface

// File: rtl/spi_host_cmd_ctrl_sdram_wr_port.sv
// Single-entry SDRAM write request register with overflow tracking.
// Ports:
//   i_clk, i_reset  : clock, async active-high reset
//   i_wr            : a load byte wants to be written this cycle
//   i_addr, i_data  : address/data of that byte
//   i_ack           : one-cycle acceptance of the current request
//   i_ovf_clr       : status byte is being read out, clear overflow
//   o_req, o_addr, o_wdata : request held until ack
//   o_overflow      : a byte arrived while the slot was still occupied
module spi_host_sdram_wr_port #(
    parameter int ADDR_W = 22
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    input  logic              i_ack,
    input  logic              i_ovf_clr,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wdata,
    output logic              o_overflow
);

    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_overflow;
    logic              w_pending;

    // An ack in this cycle already frees the slot for an incoming byte.
    assign w_pending = r_req & ~i_ack;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_wr && !w_pending) begin
                r_req   <= 1'b1;
                r_addr  <= i_addr;
                r_wdata <= i_data;
            end else if (i_ack) begin
                r_req <= 1'b0;
            end

            // A fresh drop wins over a simultaneous status-read clear.
            if (i_wr && w_pending) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_req      = r_req;
    assign o_addr     = r_addr;
    assign o_wdata    = r_wdata;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/spi_host_cmd_ctrl.sv
// Host command sequencer: decodes SPI frames byte by byte and drives the
// SDRAM loader, key matrix, CPU run/reset and the config register. Also
// supplies the byte the shifter returns in the next slot.
// Ports:
//   i_clk, i_reset : clock, async active-high reset
//   io_bus         : interface bundle (master view), see spi_host_cmd_ctrl_if
//   o_state        : current sequencer state, for observation
module spi_host_cmd_ctrl
    import spi_host_cmd_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter int         OFFSET_W = 14,
    parameter int         BANK_W   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    spi_host_cmd_ctrl_if.master    io_bus,
    output state_t                 o_state
);

    state_t              r_state;
    state_t              w_state_next;
    logic [BANK_W-1:0]   r_bank;
    logic [OFFSET_W-1:0] r_offset;
    logic [7:0]          r_tx_data;
    logic [7:0]          r_key_x;
    logic [3:0]          r_key_y;
    logic                r_key_we;
    logic                r_cpu_reset_req;
    logic                r_cpu_run;
    logic [7:0]          r_config;

    logic w_run_set;
    logic w_cpu_rst;
    logic w_key_y_we;
    logic w_key_x_we;
    logic w_bank_we;
    logic w_stream_wr;
    logic w_cfg_we;
    logic w_stat_load;
    logic w_sdram_req;
    logic w_overflow;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run_set    = 1'b0;
        w_cpu_rst    = 1'b0;
        w_key_y_we   = 1'b0;
        w_key_x_we   = 1'b0;
        w_bank_we    = 1'b0;
        w_stream_wr  = 1'b0;
        w_cfg_we     = 1'b0;
        w_stat_load  = 1'b0;

        if (io_bus.rx_valid) begin
            case (r_state)
                ST_CMD: begin
                    case (io_bus.rx_data)
                        CMD_PING:   w_state_next = ST_DISCARD;
                        CMD_RUN: begin
                            w_run_set    = 1'b1;
                            w_state_next = ST_DISCARD;
                        end
                        CMD_KEY:    w_state_next = ST_ARG_Y;
                        CMD_LOAD:   w_state_next = ST_ARG_BANK;
                        CMD_STATUS: begin
                            w_stat_load  = 1'b1;
                            w_state_next = ST_STAT;
                        end
                        CMD_CPURST: begin
                            w_cpu_rst    = 1'b1;
                            w_state_next = ST_DISCARD;
                        end
                        CMD_CONFIG: w_state_next = ST_ARG_CFG;
                        default:    w_state_next = ST_DISCARD;
                    endcase
                end
                ST_ARG_Y: begin
                    w_key_y_we   = 1'b1;
                    w_state_next = ST_ARG_X;
                end
                ST_ARG_X: begin
                    w_key_x_we   = 1'b1;
                    w_state_next = ST_DISCARD;
                end
                ST_ARG_BANK: begin
                    w_bank_we    = 1'b1;
                    w_state_next = ST_STREAM;
                end
                ST_STREAM:  w_stream_wr  = 1'b1;
                ST_ARG_CFG: begin
                    w_cfg_we     = 1'b1;
                    w_state_next = ST_DISCARD;
                end
                ST_STAT:    w_state_next = ST_DISCARD;
                default:    w_state_next = r_state;
            endcase
        end

        // Frame boundaries override; a byte arriving with frame_end has
        // already had its effect decoded above.
        if (io_bus.frame_start || io_bus.frame_end) begin
            w_state_next = ST_CMD;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bank          <= '0;
            r_offset        <= '0;
            r_tx_data       <= ACK_BYTE;
            r_key_x         <= 8'h00;
            r_key_y         <= 4'h0;
            r_key_we        <= 1'b0;
            r_cpu_reset_req <= 1'b0;
            r_cpu_run       <= 1'b0;
            r_config        <= 8'h00;
        end else begin
            r_key_we        <= w_key_x_we;
            r_cpu_reset_req <= w_cpu_rst;

            if (w_run_set) begin
                r_cpu_run <= 1'b1;
            end else if (w_cpu_rst) begin
                r_cpu_run <= 1'b0;
            end

            if (w_key_y_we) begin
                r_key_y <= io_bus.rx_data[3:0];
            end
            if (w_key_x_we) begin
                r_key_x <= io_bus.rx_data;
            end

            // Offset advances for every stream byte, dropped or not, and
            // wraps within the bank.
            if (w_bank_we) begin
                r_bank   <= BANK_W'(io_bus.rx_data);
                r_offset <= '0;
            end else if (w_stream_wr) begin
                r_offset <= r_offset + 1'b1;
            end

            if (w_cfg_we) begin
                r_config <= io_bus.rx_data;
            end

            if (io_bus.rx_valid) begin
                r_tx_data <= w_stat_load
                    ? status_byte(w_overflow, io_bus.sdram_init_busy | w_sdram_req)
                    : ACK_BYTE;
            end
        end
    end

    spi_host_sdram_wr_port #(
        .ADDR_W(BANK_W + OFFSET_W)
    ) u_wr_port (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr       (w_stream_wr),
        .i_addr     ({r_bank, r_offset}),
        .i_data     (io_bus.rx_data),
        .i_ack      (io_bus.sdram_ack),
        .i_ovf_clr  (w_stat_load),
        .o_req      (w_sdram_req),
        .o_addr     (io_bus.sdram_address),
        .o_wdata    (io_bus.sdram_wdata),
        .o_overflow (w_overflow)
    );

    assign io_bus.sdram_req     = w_sdram_req;
    assign io_bus.tx_data       = r_tx_data;
    assign io_bus.key_we        = r_key_we;
    assign io_bus.key_y         = r_key_y;
    assign io_bus.key_x         = r_key_x;
    assign io_bus.cpu_reset_req = r_cpu_reset_req;
    assign io_bus.cpu_run       = r_cpu_run;
    assign io_bus.config_reg    = r_config;
    assign o_state              = r_state;

endmodule
